// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// alu_share_ctrl_pkg: FSM state encoding and default widths shared by the ALU-sharing controller.
// Rev 1.0
package alu_share_ctrl_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_OPCODE_WIDTH = 2;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_TIMEOUT      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Width of a counter that must hold the values 0..limit inclusive.
  function automatic int count_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arbiter.sv
`default_nettype none
// alu_share_ctrl_rr_arbiter: combinational round-robin pick of the first request at or after pointer.
// Rev 1.0
module alu_share_ctrl_rr_arbiter
  import alu_share_ctrl_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [IW:0] pos;
  logic        found;

  // One spare bit on pos lets the wrap work for non-power-of-two N.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, pointer} + (IW + 1)'(k);
      if (pos >= N_W) begin
        pos = pos - N_W;
      end
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        index = pos[IW-1:0];
      end
    end
    if (found) begin
      grant[index] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// alu_share_ctrl: shares one two-beat opcode/data ALU between NUM_REQ requesters, round-robin.
// Rev 1.0
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0] req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_result,
  output logic                            rsp_overflow,
  output logic                            rsp_error,
  output logic                            busy,
  output logic                            proto_err,
  output logic                            alu_opcode_valid,
  output logic [OPCODE_WIDTH-1:0]         alu_opcode,
  output logic [DATA_WIDTH-1:0]           alu_data,
  input  logic                            alu_done,
  input  logic [DATA_WIDTH-1:0]           alu_result,
  input  logic                            alu_overflow
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = count_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

  state_t                  state;
  logic [IW-1:0]           pointer;
  logic [IW-1:0]           owner;
  logic [NUM_REQ-1:0]      owner_oh;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [CW-1:0]           wait_cnt;

  logic [NUM_REQ-1:0]      win_grant;
  logic [IW-1:0]           win_index;

  logic [OPCODE_WIDTH-1:0] op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   b_arr  [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_arr[i] = req_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
      assign a_arr[i]  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[i]  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  alu_share_ctrl_rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req    (req),
    .pointer(pointer),
    .grant  (win_grant),
    .index  (win_index)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      pointer          <= '0;
      owner            <= '0;
      owner_oh         <= '0;
      b_q              <= '0;
      wait_cnt         <= '0;
      ack              <= '0;
      rsp_valid        <= '0;
      rsp_result       <= '0;
      rsp_overflow     <= 1'b0;
      rsp_error        <= 1'b0;
      busy             <= 1'b0;
      proto_err        <= 1'b0;
      alu_opcode_valid <= 1'b0;
      alu_opcode       <= '0;
      alu_data         <= '0;
    end else begin
      ack       <= '0;
      rsp_valid <= '0;

      // A done pulse is only meaningful while an operation is outstanding.
      if (alu_done && (state != ST_WAIT)) begin
        proto_err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (|req) begin
            owner            <= win_index;
            owner_oh         <= win_grant;
            b_q              <= b_arr[win_index];
            ack              <= win_grant;
            alu_opcode_valid <= 1'b1;
            alu_opcode       <= op_arr[win_index];
            alu_data         <= a_arr[win_index];
            busy             <= 1'b1;
            state            <= ST_SEND_A;
          end
        end

        ST_SEND_A: begin
          alu_opcode_valid <= 1'b0;
          alu_opcode       <= '0;
          alu_data         <= b_q;
          state            <= ST_SEND_B;
        end

        ST_SEND_B: begin
          alu_data <= '0;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          // done is checked first so it wins over a simultaneous timeout.
          if (alu_done) begin
            rsp_valid    <= owner_oh;
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_error    <= 1'b0;
            state        <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_valid    <= owner_oh;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b1;
            state        <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        ST_RESP: begin
          rsp_result   <= '0;
          rsp_overflow <= 1'b0;
          rsp_error    <= 1'b0;
          pointer      <= (owner == LAST_REQ) ? '0 : owner + IW'(1);
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// tb_alu_share_ctrl: randomized bench with a schedule-based reference model and a bus-level ALU model.
module tb_alu_share_ctrl;

  localparam int DW = 8;
  localparam int OW = 2;
  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*OW-1:0] req_opcode;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    ack;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_result;
  logic            rsp_overflow;
  logic            rsp_error;
  logic            busy;
  logic            proto_err;
  logic            alu_opcode_valid;
  logic [OW-1:0]   alu_opcode;
  logic [DW-1:0]   alu_data;
  logic            alu_done;
  logic [DW-1:0]   alu_result;
  logic            alu_overflow;

  always #5 clk = ~clk;

  alu_share_ctrl #(
    .DATA_WIDTH  (DW),
    .OPCODE_WIDTH(OW),
    .NUM_REQ     (N),
    .TIMEOUT     (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .req_opcode      (req_opcode),
    .req_a           (req_a),
    .req_b           (req_b),
    .ack             (ack),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .rsp_overflow    (rsp_overflow),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .proto_err       (proto_err),
    .alu_opcode_valid(alu_opcode_valid),
    .alu_opcode      (alu_opcode),
    .alu_data        (alu_data),
    .alu_done        (alu_done),
    .alu_result      (alu_result),
    .alu_overflow    (alu_overflow)
  );

  int n        = 0;
  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model: one operation is a schedule anchored at its grant edge m_g.
  bit            m_active = 1'b0;
  int            m_g, m_owner, m_d, m_wlen;
  int            m_ptr    = 0;
  bit            m_proto  = 1'b0;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_res;
  logic          m_ovf, m_err;

  logic [N-1:0]  e_ack, e_rv;
  logic [DW-1:0] e_res, e_data;
  logic [OW-1:0] e_opc;
  logic          e_ovf, e_err, e_busy, e_proto, e_ov;

  int forced_d  = -1;
  bit hold_req  = 1'b0;
  bit spur_done = 1'b0;

  logic [OW-1:0] cap_op;
  logic [DW-1:0] cap_a, cap_b;
  bit            prev_ov = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, n);
  endtask

  function automatic logic [DW:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (op)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a} + {1'b0, b};
      2'd2:    return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int pick_d();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return TO;
    return int'($urandom_range(1, 4));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 32'(ack), 32'(e_ack));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("rsp_result", 32'(rsp_result), 32'(e_res));
      check("rsp_overflow", 32'(rsp_overflow), 32'(e_ovf));
      check("rsp_error", 32'(rsp_error), 32'(e_err));
      check("busy", 32'(busy), 32'(e_busy));
      check("proto_err", 32'(proto_err), 32'(e_proto));
      check("alu_opcode_valid", 32'(alu_opcode_valid), 32'(e_ov));
      check("alu_opcode", 32'(alu_opcode), 32'(e_opc));
      check("alu_data", 32'(alu_data), 32'(e_data));
    end
  end

  task automatic compute_exp();
    int k;
    e_ack = '0; e_rv = '0; e_res = '0; e_data = '0; e_opc = '0;
    e_ovf = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_ov = 1'b0;
    e_proto = m_proto;
    if (m_active) begin
      k = n - m_g;
      e_busy = (k >= 0) && (k <= 2 + m_wlen);
      if (k == 0) begin
        e_ack = N'(1) << m_owner; e_ov = 1'b1; e_opc = m_op; e_data = m_a;
      end
      if (k == 1) e_data = m_b;
      if (k == 2 + m_wlen) begin
        e_rv = N'(1) << m_owner; e_res = m_res; e_ovf = m_ovf; e_err = m_err;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
    if (prev_ov) cap_b = alu_data;
    if (alu_opcode_valid) begin
      cap_op = alu_opcode;
      cap_a  = alu_data;
    end
    prev_ov = alu_opcode_valid;
    compute_exp();
  endtask

  task automatic grant_model(input int g);
    logic [DW:0] r;
    m_owner = rr_pick(req, m_ptr);
    m_op    = req_opcode[m_owner*OW +: OW];
    m_a     = req_a[m_owner*DW +: DW];
    m_b     = req_b[m_owner*DW +: DW];
    m_d     = (forced_d >= 0) ? forced_d : pick_d();
    m_wlen  = (m_d == 0) ? TO : m_d;
    if (m_d != 0) begin
      r = alu_fn(m_op, m_a, m_b);
      m_res = r[DW-1:0]; m_ovf = r[DW]; m_err = 1'b0;
    end else begin
      m_res = '0; m_ovf = 1'b0; m_err = 1'b1;
    end
    m_g      = g;
    m_active = 1'b1;
  endtask

  // Drive the ALU for the coming edge, then advance the model across it.
  task automatic adv();
    bit in_wait;
    alu_done = spur_done || (m_active && (m_d != 0) && ((n - m_g) == 1 + m_d));
    if (alu_done && !spur_done) {alu_overflow, alu_result} = alu_fn(cap_op, cap_a, cap_b);
    else begin
      alu_result   = DW'($urandom);
      alu_overflow = 1'($urandom);
    end
    if (!reset_n) begin
      m_active = 1'b0; m_ptr = 0; m_proto = 1'b0;
    end else begin
      in_wait = m_active && ((n - m_g) >= 2) && ((n - m_g) <= 1 + m_wlen);
      if (alu_done && !in_wait) m_proto = 1'b1;
      if (!m_active || ((n - m_g) >= 3 + m_wlen)) begin
        if (m_active) begin
          m_ptr    = (m_owner + 1) % N;
          m_active = 1'b0;
        end
        if (req != '0) grant_model(n + 1);
      end
    end
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req[i] = 1'b1;
    req_opcode[i*OW +: OW] = op;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // The owner drops its request after ack and scribbles over its operands.
  task automatic auto_drop();
    if (!hold_req && m_active && (n == m_g)) begin
      req[m_owner] = 1'b0;
      req_opcode[m_owner*OW +: OW] = OW'($urandom);
      req_a[m_owner*DW +: DW] = DW'($urandom);
      req_b[m_owner*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic rand_req();
    for (int i = 0; i < N; i++) begin
      if (!req[i] && ($urandom_range(0, 3) == 0))
        set_req(i, OW'($urandom), DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic step(input bit rnd);
    cyc();
    auto_drop();
    if (rnd) rand_req();
    adv();
  endtask

  task automatic reset_pulse();
    cyc(); reset_n = 1'b0; adv();
    cyc(); reset_n = 1'b1; adv();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (req != '0 || m_active); i++) step(1'b0);
    step(1'b0);
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input int idx, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input int d,
                        output int ack_c, output int rsp_c, output logic [DW-1:0] res,
                        output logic ovf, output logic err,
                        output logic [DW-1:0] da, output logic [DW-1:0] db);
    forced_d = d;
    ack_c = -1; rsp_c = -1; res = '0; ovf = 1'b0; err = 1'b0; da = '0; db = '0;
    cyc(); set_req(idx, op, a, b); adv();
    for (int c = 1; c <= 40 && rsp_c < 0; c++) begin
      step(1'b0);
      if (ack_c > 0 && c == ack_c + 1) db = alu_data;
      if (ack[idx]) begin ack_c = c; da = alu_data; end
      if (rsp_valid[idx]) begin
        rsp_c = c; res = rsp_result; ovf = rsp_overflow; err = rsp_error;
      end
    end
    step(1'b0);
    forced_d = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_c, rsp_c, acks, rsps;
    int order [5];
    logic [DW-1:0] res, da, db;
    logic ovf, err;

    reset_n = 1'b0; req = '0; req_opcode = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0;
    cyc(); chk_en = 1'b1; adv();
    repeat (2) step(1'b0);
    cyc(); reset_n = 1'b1; adv();
    cyc();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_proto_err", 32'(proto_err), 32'd0);
    adv();

    // Single request with done two cycles after SEND_B.
    run_op(0, 2'b01, 8'h05, 8'h03, 2, ack_c, rsp_c, res, ovf, err, da, db);
    check("t1_ack_cycle", 32'(ack_c), 32'd1);
    check("t1_data_a", 32'(da), 32'h05);
    check("t1_data_b", 32'(db), 32'h03);
    check("t1_rsp_cycle", 32'(rsp_c), 32'd5);
    check("t1_result", 32'(res), 32'h08);
    check("t1_overflow", 32'(ovf), 32'd0);

    // Overflow pass-through.
    run_op(0, 2'b01, 8'hFF, 8'h01, 2, ack_c, rsp_c, res, ovf, err, da, db);
    check("t2_result", 32'(res), 32'h00);
    check("t2_overflow", 32'(ovf), 32'd1);
    check("t2_error", 32'(err), 32'd0);

    // Fairness with all requests held continuously from a fresh pointer.
    reset_pulse();
    hold_req = 1'b1; forced_d = 1; acks = 0; rsps = 0;
    cyc();
    for (int i = 0; i < N; i++) set_req(i, OW'(i), DW'(8'h10 * i), DW'(i + 1));
    adv();
    for (int c = 0; c < 60 && rsps < 5; c++) begin
      step(1'b0);
      if (ack != '0) begin
        if (acks < 5) order[acks] = rr_pick(ack, 0);
        acks++;
      end
      if (rsp_valid != '0) rsps++;
    end
    cyc(); req = '0; adv();
    hold_req = 1'b0; forced_d = -1;
    check("fair_ack_count", 32'(acks), 32'd5);
    check("fair_g0", 32'(order[0]), 32'd0);
    check("fair_g1", 32'(order[1]), 32'd1);
    check("fair_g2", 32'(order[2]), 32'd2);
    check("fair_g3", 32'(order[3]), 32'd3);
    check("fair_g4", 32'(order[4]), 32'd0);
    drain();

    // Randomized traffic with mixed done delays, including timeout and last-cycle done.
    for (int i = 0; i < 600; i++) step(1'b1);
    drain();

    // Timeout, then a normal operation.
    run_op(1, 2'b10, 8'h10, 8'h20, 0, ack_c, rsp_c, res, ovf, err, da, db);
    check("to_rsp_cycle", 32'(rsp_c), 32'd19);
    check("to_error", 32'(err), 32'd1);
    check("to_result", 32'(res), 32'd0);
    run_op(1, 2'b10, 8'h10, 8'h20, 1, ack_c, rsp_c, res, ovf, err, da, db);
    check("after_to_rsp_cycle", 32'(rsp_c), 32'd4);
    check("after_to_result", 32'(res), 32'hF0);
    check("after_to_error", 32'(err), 32'd0);

    // Spurious done while idle sets the sticky flag.
    cyc(); spur_done = 1'b1; adv();
    cyc(); spur_done = 1'b0;
    check("spur_proto_set", 32'(proto_err), 32'd1);
    adv();
    run_op(3, 2'b11, 8'h5A, 8'h0F, 2, ack_c, rsp_c, res, ovf, err, da, db);
    check("spur_op_result", 32'(res), 32'h55);
    check("spur_proto_sticky", 32'(proto_err), 32'd1);

    // Reset during WAIT, with requester 2 pending.
    forced_d = 0;
    cyc(); set_req(0, 2'b01, 8'h11, 8'h22); adv();
    repeat (5) step(1'b0);
    cyc(); reset_n = 1'b0; set_req(2, 2'b11, 8'h0F, 8'hF0); adv();
    forced_d = 1;
    cyc(); reset_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_proto_err", 32'(proto_err), 32'd0);
    adv();
    cyc();
    check("midrst_regrant", 32'(ack), 32'b0100);
    auto_drop(); adv();
    drain();
    forced_d = -1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
